// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Handshake bundle between the control FSM, the mult/div
//               sequencer and the HI/LO commit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if;
    logic req;
    logic op;
    logic mult_fim;
    logic div_fim;
    logic div_zero;
    logic busy;
    logic done;
    logic mult_start;
    logic div_start;
    logic hi_sel;
    logic lo_sel;
    logic hi_write;
    logic lo_write;
    logic exc_dz;
    logic exc_timeout;

    // Controller / unit side: drives requests and unit status, observes the sequencer.
    modport master (
        output req, op, mult_fim, div_fim, div_zero,
        input  busy, done, mult_start, div_start, hi_sel, lo_sel,
               hi_write, lo_write, exc_dz, exc_timeout
    );

    // Sequencer side.
    modport slave (
        input  req, op, mult_fim, div_fim, div_zero,
        output busy, done, mult_start, div_start, hi_sel, lo_sel,
               hi_write, lo_write, exc_dz, exc_timeout
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module      : muldiv_sequencer
// Description : Starts the multiplier or divisor, waits for completion and
//               commits the result to HI/LO, flagging divide-by-zero/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic         clock,
    input  wire logic         reset,
    muldiv_sequencer_if.slave bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_COMMIT = 3'd3;
    localparam logic [2:0] c_ERR    = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_nextState;
    logic             r_opQ;
    logic             r_reasonDz;
    logic [CNT_W-1:0] r_waitCnt;

    logic w_fim;
    logic w_dz;
    logic w_timeout;

    // Only the selected unit is observed; div_zero is meaningless for a multiply.
    assign w_fim     = r_opQ ? bus.div_fim : bus.mult_fim;
    assign w_dz      = r_opQ & bus.div_zero;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_waitCnt == c_TO_LAST);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:   if (bus.req) w_nextState = c_START;
            c_START:  w_nextState = c_WAIT;
            c_WAIT: begin
                if (w_dz)           w_nextState = c_ERR;
                else if (w_fim)     w_nextState = c_COMMIT;
                else if (w_timeout) w_nextState = c_ERR;
            end
            c_COMMIT: w_nextState = c_IDLE;
            c_ERR:    w_nextState = c_IDLE;
            default:  w_nextState = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_opQ      <= 1'b0;
            r_reasonDz <= 1'b0;
            r_waitCnt  <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                c_IDLE: begin
                    if (bus.req) r_opQ <= bus.op;
                end
                c_START: begin
                    r_waitCnt <= '0;
                end
                c_WAIT: begin
                    // Saturate so a disabled watchdog never wraps into a false match.
                    if (r_waitCnt != c_CNT_MAX) r_waitCnt <= r_waitCnt + 1'b1;
                    r_reasonDz <= w_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state != c_IDLE);
    assign bus.mult_start  = (r_state == c_START) & ~r_opQ;
    assign bus.div_start   = (r_state == c_START) &  r_opQ;
    assign bus.hi_sel      = (r_state != c_IDLE) & r_opQ;
    assign bus.lo_sel      = (r_state != c_IDLE) & r_opQ;
    assign bus.hi_write    = (r_state == c_COMMIT);
    assign bus.lo_write    = (r_state == c_COMMIT);
    assign bus.done        = (r_state == c_COMMIT);
    assign bus.exc_dz      = (r_state == c_ERR) &  r_reasonDz;
    assign bus.exc_timeout = (r_state == c_ERR) & ~r_reasonDz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer (default and
//               short-watchdog instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nAsserts = 0;
    int   nFail    = 0;

    always #5 clock = ~clock;

    muldiv_sequencer_if busA ();
    muldiv_sequencer_if busB ();

    muldiv_sequencer #(.TIMEOUT_CYCLES(64)) dutA (.clock(clock), .reset(reset), .bus(busA));
    muldiv_sequencer #(.TIMEOUT_CYCLES(8))  dutB (.clock(clock), .reset(reset), .bus(busB));

    // Bit order: busy done mult_start div_start hi_sel lo_sel hi_write lo_write exc_dz exc_timeout
    wire [9:0] outA = {busA.busy, busA.done, busA.mult_start, busA.div_start, busA.hi_sel,
                       busA.lo_sel, busA.hi_write, busA.lo_write, busA.exc_dz, busA.exc_timeout};
    wire [9:0] outB = {busB.busy, busB.done, busB.mult_start, busB.div_start, busB.hi_sel,
                       busB.lo_sel, busB.hi_write, busB.lo_write, busB.exc_dz, busB.exc_timeout};

    localparam logic [9:0] c_IDLE     = 10'b0000000000;
    localparam logic [9:0] c_START_M  = 10'b1010000000;
    localparam logic [9:0] c_START_D  = 10'b1001110000;
    localparam logic [9:0] c_WAIT_M   = 10'b1000000000;
    localparam logic [9:0] c_WAIT_D   = 10'b1000110000;
    localparam logic [9:0] c_COMMIT_M = 10'b1100001100;
    localparam logic [9:0] c_COMMIT_D = 10'b1100111100;
    localparam logic [9:0] c_ERR_DZ   = 10'b1000110010;
    localparam logic [9:0] c_ERR_TO_M = 10'b1000000001;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        busA.req = 0; busA.op = 0; busA.mult_fim = 0; busA.div_fim = 0; busA.div_zero = 0;
        busB.req = 0; busB.op = 0; busB.mult_fim = 0; busB.div_fim = 0; busB.div_zero = 0;

        tick(); tick();
        chk("reset_A", outA, c_IDLE);
        chk("reset_B", outB, c_IDLE);
        reset = 0;

        // Multiply: req in cycle 1, start in 2, WAIT 3..10, fim sampled at end of 10.
        busA.req = 1; busA.op = 0;
        tick();
        chk("mul_start", outA, c_START_M);
        busA.req = 0;
        tick();
        chk("mul_wait_first", outA, c_WAIT_M);
        for (int i = 4; i <= 10; i++) begin
            tick();
            chk("mul_wait", outA, c_WAIT_M);
        end
        busA.mult_fim = 1;
        tick();
        chk("mul_commit", outA, c_COMMIT_M);
        busA.mult_fim = 0;
        tick();
        chk("mul_idle", outA, c_IDLE);

        // Divide, 33 WAIT cycles, mult_fim toggling throughout.
        busA.req = 1; busA.op = 1;
        tick();
        chk("div_start", outA, c_START_D);
        busA.req = 0; busA.op = 0;
        for (int i = 0; i < 33; i++) begin
            tick();
            chk("div_wait", outA, c_WAIT_D);
            busA.mult_fim = ~busA.mult_fim;
            if (i == 32) busA.div_fim = 1;
        end
        tick();
        chk("div_commit", outA, c_COMMIT_D);
        busA.div_fim = 0; busA.mult_fim = 0;
        tick();
        chk("div_idle", outA, c_IDLE);

        // Divide by zero coincident with div_fim: exception wins.
        busA.req = 1; busA.op = 1;
        tick();
        chk("dz_start", outA, c_START_D);
        busA.req = 0;
        tick();
        chk("dz_wait", outA, c_WAIT_D);
        busA.div_zero = 1; busA.div_fim = 1;
        tick();
        chk("dz_err", outA, c_ERR_DZ);
        busA.div_zero = 0; busA.div_fim = 0;
        tick();
        chk("dz_idle", outA, c_IDLE);

        // div_zero and div_fim are ignored during a multiply.
        busA.req = 1; busA.op = 0;
        tick();
        busA.req = 0;
        tick();
        busA.div_zero = 1; busA.div_fim = 1;
        tick();
        chk("mul_ignore_div", outA, c_WAIT_M);
        busA.div_zero = 0; busA.div_fim = 0; busA.mult_fim = 1;
        tick();
        chk("mul_commit2", outA, c_COMMIT_M);
        busA.mult_fim = 0;
        tick();
        chk("mul_idle2", outA, c_IDLE);

        // Watchdog of 8: eight WAIT cycles with no fim, then a timeout pulse.
        busB.req = 1; busB.op = 0;
        tick();
        chk("to_start", outB, c_START_M);
        busB.req = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_wait", outB, c_WAIT_M);
        end
        tick();
        chk("to_err", outB, c_ERR_TO_M);
        tick();
        chk("to_idle", outB, c_IDLE);

        // fim in the 8th WAIT cycle beats the watchdog.
        busB.req = 1; busB.op = 1;
        tick();
        chk("to_fim_start", outB, c_START_D);
        busB.req = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_fim_wait", outB, c_WAIT_D);
            if (i == 7) busB.div_fim = 1;
        end
        tick();
        chk("to_fim_commit", outB, c_COMMIT_D);
        busB.div_fim = 0;
        tick();
        chk("to_fim_idle", outB, c_IDLE);

        // req held while busy is ignored and does not re-latch op; reset aborts.
        busA.req = 1; busA.op = 0;
        tick();
        chk("busy_start", outA, c_START_M);
        busA.op = 1;
        tick();
        chk("busy_wait1", outA, c_WAIT_M);
        tick();
        chk("busy_wait2", outA, c_WAIT_M);
        reset = 1;
        tick();
        chk("abort_reset", outA, c_IDLE);
        reset = 0; busA.req = 0; busA.op = 0; busA.mult_fim = 1;
        tick();
        chk("abort_fim", outA, c_IDLE);
        busA.mult_fim = 0;
        tick();
        chk("abort_idle", outA, c_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

`default_nettype wire
